// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port synchronous RAM.
//   Requesters: instruction fetch (if_*) is read-only; load/store (mem_*) has
//   byte selects. Each access runs IDLE -> ISSUE (ram_ce for one cycle) ->
//   RESP (one-cycle ack). A new decision is taken in RESP, so back-to-back
//   traffic gets one access every two cycles.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request and byte address
//   if_rdata/if_ack                fetch data (held between acks), ack pulse
//   mem_req/we/sel/addr/wdata      load/store request
//   mem_rdata/mem_ack              load data (0 for stores, held), ack pulse
//   ram_ce/we/sel/addr/wdata       RAM command; ram_rdata valid the cycle after ce
// Build option: define MEM_ARBITER_FAIR_EN to add the fetch starvation counter;
//   otherwise mem always beats if.
module mem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [3:0]        mem_sel,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [3:0]        ram_sel,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e              r_state;
   logic                r_win_if;
   logic                r_we;
   logic [3:0]          r_sel;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_ram_ce;
   logic                r_if_ack;
   logic                r_mem_ack;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_mem_rdata;

   logic w_decide;
   logic w_grant_if;
   logic w_force_if;

   // Decisions happen in IDLE and in RESP (overlapping the ack cycle).
   assign w_decide   = ((r_state == StIdle) || (r_state == StResp)) && (if_req || mem_req);
   assign w_grant_if = if_req && (!mem_req || w_force_if);

`ifdef MEM_ARBITER_FAIR_EN
   localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

   logic [CntW-1:0] r_starve;

   assign w_force_if = (r_starve >= Limit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve <= '0;
      end else if (w_decide) begin
         if (w_grant_if) begin
            r_starve <= '0;
         end else if (if_req && (r_starve < Limit)) begin
            r_starve <= r_starve + 1'b1;
         end
      end
   end
`else
   assign w_force_if = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_win_if    <= 1'b0;
         r_we        <= 1'b0;
         r_sel       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_ram_ce    <= 1'b0;
         r_if_ack    <= 1'b0;
         r_mem_ack   <= 1'b0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
      end else begin
         r_ram_ce  <= 1'b0;
         r_if_ack  <= 1'b0;
         r_mem_ack <= 1'b0;

         // Capture returned data at the end of the ack cycle so it holds afterwards.
         if (r_if_ack) begin
            r_if_rdata <= ram_rdata;
         end
         if (r_mem_ack) begin
            r_mem_rdata <= r_we ? '0 : ram_rdata;
         end

         case (r_state)
            StIssue: begin
               r_state   <= StResp;
               r_if_ack  <= r_win_if;
               r_mem_ack <= !r_win_if;
            end
            default: begin
               if (w_decide) begin
                  r_state  <= StIssue;
                  r_ram_ce <= 1'b1;
                  r_win_if <= w_grant_if;
                  if (w_grant_if) begin
                     r_we    <= 1'b0;
                     r_sel   <= 4'b1111;
                     r_addr  <= if_addr;
                     r_wdata <= '0;
                  end else begin
                     r_we    <= mem_we;
                     r_sel   <= mem_sel;
                     r_addr  <= mem_addr;
                     r_wdata <= mem_wdata;
                  end
               end else begin
                  r_state <= StIdle;
               end
            end
         endcase
      end
   end

   assign ram_ce    = r_ram_ce;
   assign ram_we    = r_we;
   assign ram_sel   = r_sel;
   assign ram_addr  = r_addr;
   assign ram_wdata = r_wdata;
   assign if_ack    = r_if_ack;
   assign mem_ack   = r_mem_ack;

   // RAM data arrives during the ack cycle itself, so it bypasses the hold register.
   assign if_rdata  = r_if_ack ? ram_rdata : r_if_rdata;
   assign mem_rdata = r_mem_ack ? (r_we ? '0 : ram_rdata) : r_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int unsigned Limit = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [3:0]  mem_sel = '0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        ram_ce;
   logic        ram_we;
   logic [3:0]  ram_sel;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(Limit)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, 64 words.
   logic [31:0] ram [0:63];
   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_sel[b]) ram[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
         end else begin
            ram_rdata <= ram[ram_addr[7:2]];
         end
      end
   end

   // Requester queues.
   typedef struct packed {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mreq_t;
   mreq_t       q_mem[$];
   logic [31:0] q_if[$];

   // Reference model state: transaction level, driven by the latency rule
   // (decision at edge e, ram_ce in cycle e+1, ack in cycle e+2, next decision at e+2).
   logic [31:0] ref_mem [0:63];
   int          m_wait;
   int          m_starve;
   bit          m_win_if;
   bit          m_we;
   logic [31:0] m_rd;
   logic [31:0] m_hold_if, m_hold_mem;
   bit          e_ce, e_if_ack, e_mem_ack, e_we;
   logic [3:0]  e_sel;
   logic [31:0] e_addr, e_wdata;

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wait = 0; m_starve = 0; m_win_if = 0; m_we = 0; m_rd = '0;
      m_hold_if = '0; m_hold_mem = '0;
      e_ce = 0; e_if_ack = 0; e_mem_ack = 0; e_we = 0; e_sel = '0; e_addr = '0; e_wdata = '0;
   endtask

   task automatic model_step();
      bit gif;
      int idx;
      e_ce = 0; e_if_ack = 0; e_mem_ack = 0;
      if (m_wait > 0) m_wait--;
      if (m_wait == 1) begin
         if (m_win_if) begin
            e_if_ack = 1; m_hold_if = m_rd;
         end else begin
            e_mem_ack = 1; m_hold_mem = m_we ? 32'h0 : m_rd;
         end
      end
      if (m_wait == 0 && (if_req || mem_req)) begin
`ifdef MEM_ARBITER_FAIR_EN
         gif = if_req && (!mem_req || m_starve >= int'(Limit));
         if (gif) m_starve = 0;
         else if (if_req && m_starve < int'(Limit)) m_starve++;
`else
         gif = if_req && !mem_req;
`endif
         m_win_if = gif;
         e_ce = 1;
         if (gif) begin
            e_we = 0; e_sel = 4'hF; e_addr = if_addr; e_wdata = '0;
         end else begin
            e_we = mem_we; e_sel = mem_sel; e_addr = mem_addr; e_wdata = mem_wdata;
         end
         m_we = e_we;
         idx = int'(e_addr[7:2]);
         m_rd = ref_mem[idx];
         if (e_we) begin
            for (int b = 0; b < 4; b++) begin
               if (e_sel[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
            end
         end
         m_wait = 2;
      end
   endtask

   task automatic check_outputs();
      chk("if_ack", 64'(if_ack), 64'(e_if_ack));
      chk("mem_ack", 64'(mem_ack), 64'(e_mem_ack));
      chk("ram_ce", 64'(ram_ce), 64'(e_ce));
      if (e_ce) begin
         chk("ram_addr", 64'(ram_addr), 64'(e_addr));
         chk("ram_we", 64'(ram_we), 64'(e_we));
         chk("ram_sel", 64'(ram_sel), 64'(e_sel));
         if (e_we) chk("ram_wdata", 64'(ram_wdata), 64'(e_wdata));
      end
      chk("if_rdata", 64'(if_rdata), 64'(m_hold_if));
      chk("mem_rdata", 64'(mem_rdata), 64'(m_hold_mem));
   endtask

   task automatic drive();
      if_req  = (q_if.size() != 0);
      if_addr = (q_if.size() != 0) ? q_if[0] : 32'h0;
      mem_req = (q_mem.size() != 0);
      if (q_mem.size() != 0) begin
         mem_we = q_mem[0].we; mem_sel = q_mem[0].sel;
         mem_addr = q_mem[0].addr; mem_wdata = q_mem[0].wdata;
      end else begin
         mem_we = 0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
      end
   endtask

   // One clock: model at the rising edge, check at the falling edge, then the
   // requesters react to any ack (drop or present the next request).
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
      if (if_ack && q_if.size() != 0) void'(q_if.pop_front());
      if (mem_ack && q_mem.size() != 0) void'(q_mem.pop_front());
      drive();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((q_if.size() != 0 || q_mem.size() != 0 || m_wait != 0) && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_pending", 64'(q_if.size() + q_mem.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ram_ce"}, 64'(ram_ce), 64'd0);
      chk({tag, "_ram_we"}, 64'(ram_we), 64'd0);
      chk({tag, "_ram_sel"}, 64'(ram_sel), 64'd0);
      chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
      chk({tag, "_ram_wdata"}, 64'(ram_wdata), 64'd0);
      chk({tag, "_if_ack"}, 64'(if_ack), 64'd0);
      chk({tag, "_mem_ack"}, 64'(mem_ack), 64'd0);
      chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
      chk({tag, "_mem_rdata"}, 64'(mem_rdata), 64'd0);
   endtask

   initial begin
      int n_mem, n_if, n_ce, guard, exp_if;
      mreq_t r;

      for (int i = 0; i < 64; i++) begin
         ram[i] <= 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
         ref_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      end
      ram[4] <= 32'h3402_0001;
      ref_mem[4] = 32'h3402_0001;
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 0;

      // Single fetch of 0x10.
      q_if.push_back(32'h10);
      drive();
      cycle();
      chk("fetch_ce", 64'(ram_ce), 64'd1);
      cycle();
      chk("fetch_ack", 64'(if_ack), 64'd1);
      chk("fetch_data", 64'(if_rdata), 64'h3402_0001);
      drain(10);

      // Collision: store wins, fetch follows two cycles later.
      q_mem.push_back('{we: 1'b1, sel: 4'hF, addr: 32'h20, wdata: 32'hDEAD_BEEF});
      q_if.push_back(32'h10);
      drive();
      cycle();
      cycle();
      chk("coll_mem_ack", 64'(mem_ack), 64'd1);
      chk("coll_if_ack_low", 64'(if_ack), 64'd0);
      cycle();
      cycle();
      chk("coll_if_ack", 64'(if_ack), 64'd1);
      chk("coll_ram", 64'(ram[8]), 64'hDEAD_BEEF);
      drain(10);

      // Byte store into the word just written.
      q_mem.push_back('{we: 1'b1, sel: 4'b0010, addr: 32'h20, wdata: 32'h0000_AB00});
      drive();
      cycle();
      cycle();
      chk("byte_ack", 64'(mem_ack), 64'd1);
      chk("byte_rdata", 64'(mem_rdata), 64'd0);
      drain(10);
      chk("byte_ram", 64'(ram[8]), 64'hDEAD_ABEF);

      // Reset during ISSUE of a fetch: access aborted, retried after release.
      q_if.push_back(32'h30);
      drive();
      cycle();
      chk("rst_pre_ce", 64'(ram_ce), 64'd1);
      rst = 1;
      #1;
      check_all_zero("rst_mid");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check_all_zero("rst_held");
      rst = 0;
      cycle();
      chk("rst_after_ce", 64'(ram_ce), 64'd1);
      cycle();
      chk("rst_after_ack", 64'(if_ack), 64'd1);
      chk("rst_after_data", 64'(if_rdata), 64'(ref_mem[12]));
      drain(10);

      // Back-to-back loads.
      for (int i = 0; i < 3; i++)
         q_mem.push_back('{we: 1'b0, sel: 4'hF, addr: 32'(i * 4), wdata: 32'h0});
      drive();
      n_mem = 0; n_ce = 0;
      for (int i = 0; i < 7; i++) begin
         cycle();
         if (mem_ack) n_mem++;
         if (ram_ce) n_ce++;
      end
      chk("b2b_acks", 64'(n_mem), 64'd3);
      chk("b2b_ces", 64'(n_ce), 64'd3);
      drain(10);

      // Both requesters held busy: fairness decides whether fetch gets through.
      for (int i = 0; i < 10; i++)
         q_mem.push_back('{we: 1'b0, sel: 4'hF, addr: 32'(i * 4), wdata: 32'h0});
      for (int i = 0; i < 3; i++) q_if.push_back(32'(32 + i * 4));
      drive();
      n_mem = 0; n_if = 0; guard = 0;
      while (n_mem < 10 && guard < 60) begin
         cycle();
         if (mem_ack) n_mem++;
         if (if_ack) n_if++;
         guard++;
      end
`ifdef MEM_ARBITER_FAIR_EN
      exp_if = 2;
`else
      exp_if = 0;
`endif
      chk("fair_mem_acks", 64'(n_mem), 64'd10);
      chk("fair_if_acks", 64'(n_if), 64'(exp_if));
      drain(20);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if (q_if.size() < 2 && $urandom_range(0, 3) == 0)
            q_if.push_back(32'($urandom_range(0, 15)) << 2);
         if (q_mem.size() < 2 && $urandom_range(0, 2) == 0) begin
            r.we    = 1'($urandom_range(0, 1));
            r.sel   = 4'($urandom_range(1, 15));
            r.addr  = 32'($urandom_range(0, 15)) << 2;
            r.wdata = $urandom;
            q_mem.push_back(r);
         end
         drive();
         cycle();
      end
      drain(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, RAM byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch losses before forced fetch grant.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports if_req input 1 / if_addr input ADDR_W: instruction-fetch read request and address.
REQ-007 SHALL have ports if_rdata output DATA_W / if_ack output 1: fetch data and one-cycle completion pulse.
REQ-008 SHALL have ports mem_req input 1, mem_we input 1, mem_sel input 4, mem_addr input ADDR_W, mem_wdata input DATA_W: load/store request.
REQ-009 SHALL have ports mem_rdata output DATA_W / mem_ack output 1: load data and one-cycle completion pulse.
REQ-010 SHALL have ports ram_ce, ram_we output 1; ram_sel output 4; ram_addr output ADDR_W; ram_wdata output DATA_W; ram_rdata input DATA_W: single-port synchronous RAM.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-012 IDLE: no request -> stay; any request -> latch winner's addr/we/sel/wdata into registers, go ISSUE.
REQ-013 ISSUE: ram_ce=1 for exactly one cycle with latched ram_addr/ram_we/ram_sel/ram_wdata; go RESP.
REQ-014 RESP: winner's ack=1 for exactly one cycle, its rdata=ram_rdata (loads/fetches; 0 for stores); same-cycle arbitration of pending requests, go ISSUE if any, else IDLE.
REQ-015 Latency: request sampled at edge k -> ram_ce high cycle k+1 -> ack high cycle k+2; peak throughput one access per 2 cycles.
REQ-016 Fetches SHALL force ram_we=0, ram_sel=4'b1111.
REQ-017 Default priority: mem beats if when both requested at a decision point.
REQ-018 Requesters SHALL hold req and payload stable until ack; arbiter latches payload at decision, later changes ignored for that access.
REQ-019 Requester deasserting req before ack: access still completes, ack still pulses.
REQ-020 Non-winner ack SHALL stay 0; at most one ack high per cycle; ram_ce=0 in IDLE and RESP.
REQ-021 if_rdata/mem_rdata SHALL hold last value between acks.

Reset
REQ-022 rst high SHALL immediately force state IDLE, all outputs 0, latched payload 0, starvation counter 0.
REQ-023 rst mid-ISSUE/RESP SHALL abort the access; no ack emitted for it after rst falls.
REQ-024 First decision after rst falls occurs on first rising edge with rst low.

Configuration
REQ-025 Macro MEM_ARBITER_FAIR_EN SHALL select arbitration fairness.
REQ-026 Defined: counter increments (saturating at STARVE_LIMIT) each decision where if_req=1 but mem wins; clears when if wins; at STARVE_LIMIT, if wins next decision regardless of mem_req.
REQ-027 Undefined: strict mem priority, no counter logic present.

Verification
REQ-028 Single fetch: if_req=1, if_addr=0x10, RAM[0x10]=0x3402_0001 -> ram_ce cycle k+1 addr 0x10, if_ack cycle k+2, if_rdata=0x3402_0001.
REQ-029 Collision: if_req and mem_req (store, addr 0x20, wdata 0xDEAD_BEEF, sel 4'b1111) same edge -> store first (mem_ack k+2, RAM[0x20]=0xDEAD_BEEF), fetch ack k+4.
REQ-030 Byte store: mem_sel=4'b0010, wdata 0x0000_AB00 at 0x20 holding 0xDEAD_BEEF -> RAM[0x20]=0xDEAD_ABEF, mem_rdata unchanged value 0.
REQ-031 Fairness: mem_req and if_req held high continuously -> with MEM_ARBITER_FAIR_EN, if_ack after 4 mem_acks then repeats every 5th ack; without it, if_ack never asserts.
REQ-032 Reset mid-op: rst pulsed during ISSUE of a fetch -> no if_ack, all outputs 0 during rst, next access after release completes normally with 2-cycle latency.
REQ-033 Back-to-back: mem_req held for 3 loads -> ram_ce on alternating cycles, three mem_ack pulses 2 cycles apart, no IDLE visit.
